secret_accum_resp: RTL and testbench
====================================

# secret_accum_resp

Responder end of the protected-library accumulator interface: accepts accumulate requests over a valid/ready channel, adds each operand plus a hidden constant into a 32-bit running total, and returns the total and an echoed payload over a valid/ready response channel. It sits behind the protect-lib boundary as the synthesizable counterpart to the initiator benches that drive `accum_in` and check `accum_out`, `accum_bypass_out` and the `sN_in`/`sN_out` loopback signals.

## Interface
- `SECRET_VALUE`, 7, constant added on every accepted request
- `ACC_W`, 32, accumulator/operand width
- `ECHO_W`, 129, loopback payload width (must be ≥1)
- `clk` in 1 — sole clock, all state on posedge
- `rst` in 1 — synchronous, active-high reset
- `req_valid` in 1 — request present
- `req_ready` out 1 — responder can accept
- `accum_in` in ACC_W — operand
- `accum_bypass` in 1 — select bypass view (level, not handshaked)
- `echo_in` in ECHO_W — payload captured with request
- `rsp_valid` out 1 — response present
- `rsp_ready` in 1 — initiator takes response
- `accum_out` out ACC_W — running total after the accepted request
- `accum_bypass_out` out ACC_W — `accum_bypass ? last accepted accum_in : accum_out`
- `echo_out` out ECHO_W — payload of the request that produced the current response
- `txn_count` out 16 — accepted-request count

## Operation
- Accept = `req_valid && req_ready`; `req_ready = !rsp_valid || rsp_ready` (combinational, no request-to-ready path through `req_valid`).
- On accept: `acc <= acc + accum_in + SECRET_VALUE`, modulo 2^ACC_W (sum formed at ACC_W+2 bits, truncated); `last_in <= accum_in`; `echo_out <= echo_in`; `txn_count <= txn_count + 1` (wraps 0xFFFF→0); `rsp_valid <= 1`.
- Response register FSM, two states:
  - EMPTY: `rsp_valid=0`; accept → FULL.
  - FULL: `rsp_valid=1`, outputs held stable; `rsp_ready && !accept` → EMPTY; `rsp_ready && accept` → stay FULL with new data (back-to-back, full throughput); `!rsp_ready` → hold, `req_ready=0`.
- `accum_out` always reflects `acc`, also when `rsp_valid=0`.
- `accum_bypass_out` is combinational from `accum_bypass`; toggling bypass never alters `acc`.
- Reset values: `acc=0`, `last_in=0`, `echo_out=0`, `txn_count=0`, `rsp_valid=0`, state EMPTY; `req_ready=1` in the cycle after reset releases. `rst` asserted mid-transaction drops a pending response without handshake; a request presented with `rst` high is not accepted.

## Timing
- Request-to-response latency: 1 cycle (response valid the cycle after accept).
- Throughput: one request per cycle while `rsp_ready=1`.
- `rsp_ready` low for N cycles stalls requests exactly N cycles; no request lost or duplicated.
- `accum_bypass` → `accum_bypass_out`: 0 cycles.

## Configuration
- `SECRET_ACCUM_SAT_EN` defined: accumulate saturates at 2^ACC_W−1 (sticky until reset); `txn_count` still wraps.
- Not defined: accumulate wraps modulo 2^ACC_W (default).

## Structure
- Package `secret_accum_pkg`: default `SECRET_VALUE`, `ACC_W`, response FSM state enum (EMPTY/FULL), `TXN_W=16`.
- One sub-module `secret_accum_rspreg`: parameterized-width response holding register plus EMPTY/FULL FSM, producing `rsp_valid`/`req_ready`; top holds arithmetic and counters.

## Test plan
- Reset, then requests 0,5,10,15 with `rsp_ready=1` every cycle → `accum_out` 7,19,36,58 on consecutive cycles; `txn_count`=4.
- FULL with `rsp_ready=0` for 3 cycles, `req_valid=1` → `req_ready=0` for 3 cycles, `accum_out`/`echo_out` held, next value accepted on release.
- `accum_bypass=1` after request 100 → `accum_bypass_out=100` same cycle; drop bypass → equals `accum_out`; `acc` unchanged.
- `echo_in` = 129-bit `{3{64'h5aef0c8d_d70a4497}}` truncated → `echo_out` matches one cycle later; repeat for all-ones and alternating patterns.
- Preload via requests to `acc=0xFFFFFFF0`, request 0x10 → wrap to 0x7 (macro off) / 0xFFFFFFFF (`SECRET_ACCUM_SAT_EN`).
- Assert `rst` while FULL with `rsp_ready=0` → next cycle `rsp_valid=0`, `accum_out=0`, `txn_count=0`, `req_ready=1`.

Source files
------------

// File: rtl/secret_accum_pkg.sv
// Shared defaults and response-FSM state type for the secret accumulator responder.
package secret_accum_pkg;

  localparam int DEFAULT_SECRET_VALUE = 7;
  localparam int DEFAULT_ACC_W        = 32;
  localparam int DEFAULT_ECHO_W       = 129;
  localparam int TXN_W                = 16;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;

endpackage

// File: rtl/secret_accum_resp_if.sv
// Request/response channel bundle between an accumulator initiator (master) and responder (slave).
interface secret_accum_resp_if
  import secret_accum_pkg::*;
#(
  parameter int ACC_W  = DEFAULT_ACC_W,
  parameter int ECHO_W = DEFAULT_ECHO_W
);

  logic              req_valid;
  logic              req_ready;
  logic [ACC_W-1:0]  accum_in;
  logic              accum_bypass;
  logic [ECHO_W-1:0] echo_in;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [ACC_W-1:0]  accum_out;
  logic [ACC_W-1:0]  accum_bypass_out;
  logic [ECHO_W-1:0] echo_out;
  logic [TXN_W-1:0]  txn_count;

  modport master (
    output req_valid, accum_in, accum_bypass, echo_in, rsp_ready,
    input  req_ready, rsp_valid, accum_out, accum_bypass_out, echo_out, txn_count
  );

  modport slave (
    input  req_valid, accum_in, accum_bypass, echo_in, rsp_ready,
    output req_ready, rsp_valid, accum_out, accum_bypass_out, echo_out, txn_count
  );

endinterface

// File: rtl/secret_accum_rspreg.sv
// Single-entry response holding register with EMPTY/FULL FSM; a new request may load
// in the same cycle the current response is taken, giving full throughput.
module secret_accum_rspreg
  import secret_accum_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  input  logic         rsp_ready,
  input  logic [W-1:0] d,
  output logic         req_ready,
  output logic         rsp_valid,
  output logic         accept,
  output logic [W-1:0] q
);

  rsp_state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RSP_EMPTY;
      q       <= '0;
    end else begin
      state_q <= state_d;
      if (accept) q <= d;
    end
  end

  // Ready depends only on the response side, never on req_valid.
  always_comb begin
    state_d   = state_q;
    rsp_valid = (state_q == RSP_FULL);
    req_ready = !rsp_valid || rsp_ready;
    accept    = req_valid && req_ready;
    case (state_q)
      RSP_EMPTY: if (accept) state_d = RSP_FULL;
      RSP_FULL:  if (rsp_ready && !accept) state_d = RSP_EMPTY;
      default:   state_d = RSP_EMPTY;
    endcase
  end

endmodule

// File: rtl/secret_accum_resp.sv
// Accumulator responder: adds operand plus a hidden constant into a running total.
// Define SECRET_ACCUM_SAT_EN to saturate the total instead of wrapping.
module secret_accum_resp
  import secret_accum_pkg::*;
#(
  parameter int SECRET_VALUE = DEFAULT_SECRET_VALUE,
  parameter int ACC_W        = DEFAULT_ACC_W,
  parameter int ECHO_W       = DEFAULT_ECHO_W
) (
  input  logic                clk,
  input  logic                rst,
  secret_accum_resp_if.slave  bus
);

  logic              accept;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_next;
  logic [ACC_W-1:0]  last_in;
  logic [TXN_W-1:0]  txn_count;
  logic [ACC_W+1:0]  sum;

  secret_accum_rspreg #(.W(ECHO_W)) u_rspreg (
    .clk       (clk),
    .rst       (rst),
    .req_valid (bus.req_valid),
    .rsp_ready (bus.rsp_ready),
    .d         (bus.echo_in),
    .req_ready (bus.req_ready),
    .rsp_valid (bus.rsp_valid),
    .accept    (accept),
    .q         (bus.echo_out)
  );

  assign sum = {2'b00, acc} + {2'b00, bus.accum_in} + (ACC_W+2)'(SECRET_VALUE);

`ifdef SECRET_ACCUM_SAT_EN
  // Once pinned at full scale the total stays there until reset.
  always_comb begin
    acc_next = sum[ACC_W-1:0];
    if (sum[ACC_W+1:ACC_W] != 2'b00 || acc == {ACC_W{1'b1}})
      acc_next = {ACC_W{1'b1}};
  end
`else
  always_comb begin
    acc_next = sum[ACC_W-1:0];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      last_in   <= '0;
      txn_count <= '0;
    end else if (accept) begin
      acc       <= acc_next;
      last_in   <= bus.accum_in;
      txn_count <= txn_count + 1'b1;
    end
  end

  assign bus.accum_out        = acc;
  assign bus.accum_bypass_out = bus.accum_bypass ? last_in : acc;
  assign bus.txn_count        = txn_count;

endmodule

// File: tb/tb_secret_accum_resp.sv
// Directed bench for secret_accum_resp with a queue scoreboard of expected responses.
module tb_secret_accum_resp;

  typedef struct {
    logic [31:0]  acc;
    logic [128:0] echo;
    logic [15:0]  cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  exp_t         sb[$];
  logic         model_full = 1'b0;
  logic [31:0]  model_acc  = '0;
  logic [15:0]  model_cnt  = '0;
  logic [128:0] pat_a, pat_b, pat_c;
  logic [191:0] wide_tmp;
  logic [129:0] alt_tmp;

  secret_accum_resp_if bus ();

  secret_accum_resp dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_acc(input logic [31:0] a, input logic [31:0] d);
    logic [33:0] s;
    s = {2'b00, a} + {2'b00, d} + 34'd7;
`ifdef SECRET_ACCUM_SAT_EN
    if (s[33:32] != 2'b00 || a == 32'hFFFF_FFFF) return 32'hFFFF_FFFF;
`endif
    return s[31:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [128:0] obs, input logic [128:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; expectations come from the model and the scoreboard.
  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic [128:0] e,
                               input logic rr);
    logic exp_ready, acc_ok, consumed;
    exp_t ent;
    @(negedge clk);
    bus.req_valid = v;
    bus.accum_in  = d;
    bus.echo_in   = e;
    bus.rsp_ready = rr;
    #1;
    exp_ready = !model_full || rr;
    checkOutput("req_ready", {128'd0, bus.req_ready}, {128'd0, exp_ready});
    acc_ok   = v && exp_ready;
    consumed = model_full && rr;
    @(posedge clk);
    #1;
    if (consumed && sb.size() > 0) void'(sb.pop_front());
    if (acc_ok) begin
      model_acc = ref_acc(model_acc, d);
      model_cnt = model_cnt + 16'd1;
      ent.acc = model_acc; ent.echo = e; ent.cnt = model_cnt;
      sb.push_back(ent);
    end
    model_full = acc_ok || (model_full && !rr);
    checkOutput("rsp_valid", {128'd0, bus.rsp_valid}, {128'd0, model_full});
    checkOutput("accum_out", {97'd0, bus.accum_out}, {97'd0, model_acc});
    checkOutput("txn_count", {113'd0, bus.txn_count}, {113'd0, model_cnt});
    if (model_full && sb.size() > 0) begin
      checkOutput("sb_accum", {97'd0, bus.accum_out}, {97'd0, sb[0].acc});
      checkOutput("sb_echo", bus.echo_out, sb[0].echo);
      checkOutput("sb_count", {113'd0, bus.txn_count}, {113'd0, sb[0].cnt});
    end
  endtask

  task automatic doReset(input logic v);
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = v;
    bus.accum_in  = 32'd55;
    bus.rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 1'b0;
    model_full = 1'b0; model_acc = '0; model_cnt = '0;
    sb.delete();
    #1;
    checkOutput("rst_rsp_valid", {128'd0, bus.rsp_valid}, 129'd0);
    checkOutput("rst_accum_out", {97'd0, bus.accum_out}, 129'd0);
    checkOutput("rst_txn_count", {113'd0, bus.txn_count}, 129'd0);
    checkOutput("rst_req_ready", {128'd0, bus.req_ready}, 129'd1);
  endtask

  initial begin
    logic [31:0] seq_exp [4];
    logic [31:0] wrap_exp;
    seq_exp = '{32'd7, 32'd19, 32'd36, 32'd58};
    bus.req_valid = 1'b0; bus.accum_in = '0; bus.accum_bypass = 1'b0;
    bus.echo_in = '0; bus.rsp_ready = 1'b1;
    wide_tmp = {3{64'h5aef0c8d_d70a4497}};
    pat_a    = wide_tmp[128:0];
    pat_b    = '1;
    alt_tmp  = {65{2'b10}};
    pat_c    = alt_tmp[128:0];

    repeat (2) @(posedge clk);
    doReset(1'b1);

    $display("[TB] back-to-back requests");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'(i * 5), 129'(i + 1), 1'b1);
      checkOutput("seq_accum", {97'd0, bus.accum_out}, {97'd0, seq_exp[i]});
    end
    checkOutput("seq_count", {113'd0, bus.txn_count}, 129'd4);

    $display("[TB] response stall");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'd20, pat_a, 1'b0);
      checkOutput("stall_accum", {97'd0, bus.accum_out}, 129'd58);
      checkOutput("stall_echo", bus.echo_out, 129'd4);
    end
    applyStimulus(1'b1, 32'd20, pat_a, 1'b1);
    checkOutput("release_accum", {97'd0, bus.accum_out}, 129'd85);
    applyStimulus(1'b0, 32'd0, '0, 1'b1);

    $display("[TB] bypass view");
    applyStimulus(1'b1, 32'd100, pat_b, 1'b1);
    bus.accum_bypass = 1'b1;
    #1;
    checkOutput("bypass_on", {97'd0, bus.accum_bypass_out}, 129'd100);
    checkOutput("bypass_acc", {97'd0, bus.accum_out}, 129'd192);
    bus.accum_bypass = 1'b0;
    #1;
    checkOutput("bypass_off", {97'd0, bus.accum_bypass_out}, 129'd192);

    $display("[TB] echo patterns");
    applyStimulus(1'b1, 32'd1, pat_a, 1'b1);
    applyStimulus(1'b1, 32'd2, pat_b, 1'b1);
    applyStimulus(1'b1, 32'd3, pat_c, 1'b1);
    checkOutput("echo_alt", bus.echo_out, pat_c);
    applyStimulus(1'b0, 32'd0, '0, 1'b1);

    $display("[TB] wrap boundary");
    applyStimulus(1'b1, 32'hFFFF_FFF0 - model_acc - 32'd7, pat_a, 1'b1);
    checkOutput("preload", {97'd0, bus.accum_out}, {97'd0, 32'hFFFF_FFF0});
    applyStimulus(1'b1, 32'h10, pat_b, 1'b1);
`ifdef SECRET_ACCUM_SAT_EN
    wrap_exp = 32'hFFFF_FFFF;
`else
    wrap_exp = 32'h0000_0007;
`endif
    checkOutput("wrap", {97'd0, bus.accum_out}, {97'd0, wrap_exp});

    $display("[TB] reset while full and stalled");
    applyStimulus(1'b1, 32'd3, pat_c, 1'b0);
    doReset(1'b1);
    applyStimulus(1'b1, 32'd1, pat_a, 1'b1);
    checkOutput("post_reset", {97'd0, bus.accum_out}, 129'd8);
    applyStimulus(1'b0, 32'd0, '0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
